tone_osc_bank: RTL and testbench

TONE_OSC_BANK -- requirements
Module: tone_osc_bank

---
 rtl/tone_osc_bank_if.sv | 24 ++
 rtl/tone_osc_bank.sv | 76 +++++++
 tb/tb_tone_osc_bank.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_osc_bank_if.sv
// Bus bundle for tone_osc_bank: per-channel enables, limits and the
// registered count/tick/square outputs. The driver uses the master
// modport and the oscillator bank uses the slave modport.
interface tone_osc_bank_if #(
  parameter int CHANNELS = 12,
  parameter int WIDTH    = 16
);
  logic [CHANNELS-1:0]       en;
  logic                      clr;
  logic [CHANNELS*WIDTH-1:0] lim;
  logic [CHANNELS*WIDTH-1:0] cnt_out;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       square;

  modport master (
    output en, clr, lim,
    input  cnt_out, tick, square
  );

  modport slave (
    input  en, clr, lim,
    output cnt_out, tick, square
  );
endinterface

// File: rtl/tone_osc_bank.sv
// tone_osc_bank: CHANNELS independent programmable tone counters.
// Each channel counts 0..lim_act and wraps, giving a one-cycle tick per
// wrap and (optionally) a 50%-duty square wave toggled on each wrap.
// Limits are taken from a shadow register loaded only while the channel
// is idle/cleared or at a wrap, so a limit change never cuts a period short.
// Optional feature macro: TONE_OSC_SQUARE_EN (square toggle registers).
// Without it, square is tied to 0 and everything else is unchanged.
module tone_osc_bank #(
  parameter int CHANNELS = 12,
  parameter int WIDTH    = 16
) (
  input logic           clk,
  input logic           rst,
  tone_osc_bank_if.slave bus
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_lim_act;
    logic             r_tick;
    logic [WIDTH-1:0] w_lim;
    logic             w_hold;
    logic             w_wrap;

    // Idle (disabled or globally cleared) channels sit at zero and keep
    // tracking the live limit so the first enabled period uses it.
    assign w_lim  = bus.lim[g*WIDTH +: WIDTH];
    assign w_hold = bus.clr | ~bus.en[g];
    assign w_wrap = (r_cnt == r_lim_act);

    // Counter, shadow limit and tick pulse for this channel.
    // NOTE: state registers use non-blocking assignments so every channel
    // samples pre-edge values, keeping the channels order-independent.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt     <= '0;
        r_lim_act <= '0;
        r_tick    <= 1'b0;
      end else if (w_hold) begin
        r_cnt     <= '0;
        r_lim_act <= w_lim;
        r_tick    <= 1'b0;
      end else if (w_wrap) begin
        r_cnt     <= '0;
        r_lim_act <= w_lim;
        r_tick    <= 1'b1;
      end else begin
        r_cnt     <= r_cnt + WIDTH'(1);
        r_tick    <= 1'b0;
      end
    end

`ifdef TONE_OSC_SQUARE_EN
    logic r_square;

    // Square output flips on every wrap, giving a 2*(lim_act+1) period.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_square <= 1'b0;
      end else if (w_hold) begin
        r_square <= 1'b0;
      end else if (w_wrap) begin
        r_square <= ~r_square;
      end
    end

    assign bus.square[g] = r_square;
`else
    assign bus.square[g] = 1'b0;
`endif

    assign bus.cnt_out[g*WIDTH +: WIDTH] = r_cnt;
    assign bus.tick[g]                   = r_tick;
  end

endmodule

// File: tb/tb_tone_osc_bank.sv
// Directed testbench for tone_osc_bank. A 12x16 instance covers the main
// scenarios; a 1x4 instance covers the all-ones limit wrap. Square checks
// follow TONE_OSC_SQUARE_EN: expected toggles when defined, constant 0 otherwise.
module tb_tone_osc_bank;

  localparam int CH = 12;
  localparam int W  = 16;
`ifdef TONE_OSC_SQUARE_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  tone_osc_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
  tone_osc_bank_if #(.CHANNELS(1),  .WIDTH(4)) nbus ();

  tone_osc_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  tone_osc_bank #(.CHANNELS(1), .WIDTH(4)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (nbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] cnt_of(input int ch);
    return bus.cnt_out[ch*W +: W];
  endfunction

  task automatic set_lim(input int ch, input logic [W-1:0] v);
    bus.lim[ch*W +: W] = v;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.en   = '0;
    bus.clr  = 1'b0;
    bus.lim  = '0;
    nbus.en  = '0;
    nbus.clr = 1'b0;
    nbus.lim = '0;
    #2;
    checks++;
    if (bus.cnt_out !== '0) begin
      $display("FAIL reset_cnt: got %0h want 0", bus.cnt_out); errors++;
    end
    checks++;
    if (bus.tick !== '0) begin
      $display("FAIL reset_tick: got %0h want 0", bus.tick); errors++;
    end
    checks++;
    if (bus.square !== '0) begin
      $display("FAIL reset_square: got %0h want 0", bus.square); errors++;
    end
    checks++;
    if (nbus.cnt_out !== '0) begin
      $display("FAIL reset_cnt_narrow: got %0h want 0", nbus.cnt_out); errors++;
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Channel 0, limit 3 loaded while disabled, then enabled.
  task automatic test_basic();
    logic [W-1:0] exp_cnt [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic         exp_tk  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic         exp_sq  [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    set_lim(0, 16'd3);
    step();
    bus.en[0] = 1'b1;
    checks++;
    if (cnt_of(0) !== '0) begin
      $display("FAIL basic_start: got %0d want 0", cnt_of(0)); errors++;
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (cnt_of(0) !== exp_cnt[k] || bus.tick[0] !== exp_tk[k] ||
          bus.square[0] !== (exp_sq[k] & SQ)) begin
        $display("FAIL basic_cyc%0d: got cnt=%0d tick=%b sq=%b want cnt=%0d tick=%b sq=%b",
                 k + 1, cnt_of(0), bus.tick[0], bus.square[0],
                 exp_cnt[k], exp_tk[k], exp_sq[k] & SQ);
        errors++;
      end
    end
    bus.en[0] = 1'b0;
    step();
    checks++;
    if (cnt_of(0) !== '0 || bus.tick[0] !== 1'b0 || bus.square[0] !== 1'b0) begin
      $display("FAIL basic_disable: got cnt=%0d tick=%b sq=%b want 0/0/0",
               cnt_of(0), bus.tick[0], bus.square[0]);
      errors++;
    end
  endtask

  // Channel 1, limit 9 running; limit changed to 2 at count 4.
  task automatic test_lim_change();
    logic [W-1:0] exp_cnt [12] = '{5, 6, 7, 8, 9, 0, 1, 2, 0, 1, 2, 0};
    logic         exp_tk  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    logic         exp_sq  [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    set_lim(1, 16'd9);
    step();
    bus.en[1] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (cnt_of(1) !== 16'd4) begin
      $display("FAIL limchg_at4: got %0d want 4", cnt_of(1)); errors++;
    end
    set_lim(1, 16'd2);
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (cnt_of(1) !== exp_cnt[k] || bus.tick[1] !== exp_tk[k] ||
          bus.square[1] !== (exp_sq[k] & SQ)) begin
        $display("FAIL limchg_cyc%0d: got cnt=%0d tick=%b sq=%b want cnt=%0d tick=%b sq=%b",
                 k + 1, cnt_of(1), bus.tick[1], bus.square[1],
                 exp_cnt[k], exp_tk[k], exp_sq[k] & SQ);
        errors++;
      end
    end
    bus.en[1] = 1'b0;
    step();
  endtask

  // Channel 2 with limit 0: tick every cycle, square alternating.
  task automatic test_zero_lim();
    logic exp_sq [4] = '{1, 0, 1, 0};
    set_lim(2, 16'd0);
    step();
    bus.en[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (cnt_of(2) !== '0 || bus.tick[2] !== 1'b1 ||
          bus.square[2] !== (exp_sq[k] & SQ)) begin
        $display("FAIL zerolim_cyc%0d: got cnt=%0d tick=%b sq=%b want cnt=0 tick=1 sq=%b",
                 k + 1, cnt_of(2), bus.tick[2], bus.square[2], exp_sq[k] & SQ);
        errors++;
      end
    end
    checks++;
    if (cnt_of(0) !== '0 || cnt_of(1) !== '0 || bus.tick[1:0] !== 2'b00) begin
      $display("FAIL zerolim_isolation: got cnt0=%0d cnt1=%0d tick=%b want 0 0 00",
               cnt_of(0), cnt_of(1), bus.tick[1:0]);
      errors++;
    end
    bus.en[2] = 1'b0;
    step();
  endtask

  // All channels with limits 0..11, 19 cycles, then a one-cycle clear.
  task automatic test_clear();
    int n;
    int p;
    for (int i = 0; i < CH; i++) set_lim(i, W'(i));
    step();
    bus.en = '1;
    n = 19;
    for (int k = 0; k < n; k++) step();
    for (int i = 0; i < CH; i++) begin
      p = i + 1;
      checks++;
      if (cnt_of(i) !== W'(n % p) || bus.tick[i] !== (n % p == 0) ||
          bus.square[i] !== (((n / p) % 2 == 1) & SQ)) begin
        $display("FAIL clear_pre_ch%0d: got cnt=%0d tick=%b sq=%b want cnt=%0d tick=%b sq=%b",
                 i, cnt_of(i), bus.tick[i], bus.square[i],
                 n % p, n % p == 0, ((n / p) % 2 == 1) & SQ);
        errors++;
      end
    end
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    checks++;
    if (bus.cnt_out !== '0 || bus.tick !== '0 || bus.square !== '0) begin
      $display("FAIL clear_all: got cnt=%0h tick=%0h sq=%0h want 0",
               bus.cnt_out, bus.tick, bus.square);
      errors++;
    end
    step();
    checks++;
    if (cnt_of(0) !== '0 || bus.tick[0] !== 1'b1 || cnt_of(5) !== 16'd1 ||
        bus.tick[5] !== 1'b0) begin
      $display("FAIL clear_restart: got c0=%0d t0=%b c5=%0d t5=%b want 0 1 1 0",
               cnt_of(0), bus.tick[0], cnt_of(5), bus.tick[5]);
      errors++;
    end
    bus.en = '0;
    step();
  endtask

  // Channel 0 limit 5, asynchronous reset at count 3.
  task automatic test_reset_mid();
    logic [W-1:0] exp_cnt [13] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    logic         exp_tk  [13] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic         exp_sq  [13] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    set_lim(0, 16'd5);
    step();
    bus.en[0] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (cnt_of(0) !== 16'd3) begin
      $display("FAIL rstmid_pre: got %0d want 3", cnt_of(0)); errors++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_of(0) !== '0 || bus.tick[0] !== 1'b0 || bus.square[0] !== 1'b0) begin
      $display("FAIL rstmid_async: got cnt=%0d tick=%b sq=%b want 0/0/0",
               cnt_of(0), bus.tick[0], bus.square[0]);
      errors++;
    end
    step();
    checks++;
    if (cnt_of(0) !== '0) begin
      $display("FAIL rstmid_hold: got %0d want 0", cnt_of(0)); errors++;
    end
    #3;
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      step();
      checks++;
      if (cnt_of(0) !== exp_cnt[k] || bus.tick[0] !== exp_tk[k] ||
          bus.square[0] !== (exp_sq[k] & SQ)) begin
        $display("FAIL rstmid_cyc%0d: got cnt=%0d tick=%b sq=%b want cnt=%0d tick=%b sq=%b",
                 k + 1, cnt_of(0), bus.tick[0], bus.square[0],
                 exp_cnt[k], exp_tk[k], exp_sq[k] & SQ);
        errors++;
      end
    end
    bus.en[0] = 1'b0;
    step();
  endtask

  // 4-bit channel with limit all-ones: counts to 15 then wraps to 0.
  task automatic test_all_ones();
    nbus.lim = 4'hF;
    step();
    nbus.en = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      checks++;
      if (nbus.cnt_out !== 4'(n % 16) || nbus.tick[0] !== (n == 16)) begin
        $display("FAIL allones_cyc%0d: got cnt=%0d tick=%b want cnt=%0d tick=%b",
                 n, nbus.cnt_out, nbus.tick[0], n % 16, n == 16);
        errors++;
      end
    end
    nbus.en = 1'b0;
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_lim_change();
    test_zero_lim();
    test_clear();
    test_reset_mid();
    test_all_ones();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
